io_led_switch_port: RTL and testbench

- IO-side responder for the memory/IO decoder of the Minisys-style CPU.
- Consumes the decoder's `LEDCtrl`/`SwitchCtrl` selects, `ioRead`/`ioWrite` strobes, low address bits and 16-bit write data.
- Drives the 24-bit board LEDs from write-only registers and returns synchronized, debounced 24-bit switch state on `io_rdata`.
- Provides a sticky "switches changed" status bit that clears on read.

---
 rtl/io_led_switch_port.sv | 203 ++++++++++++++++++++
 tb/tb_io_led_switch_port.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_led_switch_port.sv
`default_nettype none
// ============================================================================
// Module   : io_led_switch_port
// Purpose  : IO-side responder behind the Minisys memory/IO decoder. Holds the
//            24 board LEDs in write-only registers and returns synchronized,
//            optionally debounced, switch state plus a sticky change flag
//            that clears on read.
// Build    : define IO_DEBOUNCE_EN to build the debounce FSM and counter;
//            without it the synchronized switches are taken every clock.
// Ports    : clock, reset      - rising-edge clock, async active-high reset
//            ioRead, ioWrite   - IO strobes from the decoder
//            LEDCtrl           - LED block select   (0xFFFF_FC60 region)
//            SwitchCtrl        - switch block select (0xFFFF_FC70 region)
//            addr_low[2:0]     - register offset
//            io_wdata[15:0]    - write data
//            io_rdata[15:0]    - combinational read data
//            switch_in[23:0]   - raw asynchronous board switches
//            led_out[23:0]     - board LEDs
// Revision : 1.0 - initial release
// ============================================================================
module io_led_switch_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ioRead,
  input  logic        ioWrite,
  input  logic        LEDCtrl,
  input  logic        SwitchCtrl,
  input  logic [2:0]  addr_low,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  input  logic [23:0] switch_in,
  output logic [23:0] led_out
);

  localparam logic [2:0] OFS_LO   = 3'd0;
  localparam logic [2:0] OFS_HI   = 3'd2;
  localparam logic [2:0] OFS_STAT = 3'd4;

  // --------------------------------------------------------------------------
  // LED registers
  // --------------------------------------------------------------------------
  logic [23:0] led_q, led_d;

  always_comb begin
    led_d = led_q;
    if (ioWrite && LEDCtrl) begin
      if (addr_low == OFS_LO) begin
        led_d[15:0] = io_wdata;
      end else if (addr_low == OFS_HI) begin
        led_d[23:16] = io_wdata[7:0];
      end
    end
  end

  assign led_out = led_q;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous switches
  // --------------------------------------------------------------------------
  logic [23:0] sync1_q, sync1_d;
  logic [23:0] sync2_q, sync2_d;
  logic [23:0] sw_sync;

  assign sync1_d = switch_in;
  assign sync2_d = sync1_q;
  assign sw_sync = sync2_q;

  // --------------------------------------------------------------------------
  // Stable switch value and change detection
  // --------------------------------------------------------------------------
  logic [23:0] sw_stable_q, sw_stable_d;
  logic        chg_set;

`ifdef IO_DEBOUNCE_EN
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [23:0]       sw_cand_q, sw_cand_d;

  // The bounce-back test comes before the candidate-change test: while
  // counting, sw_cand always differs from sw_stable, so a return to the
  // stable value would otherwise be taken as a new candidate and later
  // re-accepted, raising a spurious change flag.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sw_cand_d   = sw_cand_q;
    sw_stable_d = sw_stable_q;
    chg_set     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sw_sync != sw_stable_q) begin
          cnt_d     = CNT_ONE;
          sw_cand_d = sw_sync;
          state_d   = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (sw_sync == sw_stable_q) begin
          state_d = ST_IDLE;
        end else if (sw_sync != sw_cand_q) begin
          cnt_d     = CNT_ONE;
          sw_cand_d = sw_sync;
        end else if (cnt_q == CNT_LAST) begin
          sw_stable_d = sw_cand_q;
          chg_set     = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sw_cand_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sw_cand_q <= sw_cand_d;
    end
  end
`else
  // Debounce parameters have no function in this build.
  logic unused_cfg;
  assign unused_cfg = ^{DEBOUNCE_CYCLES, CNT_W};

  always_comb begin
    sw_stable_d = sw_sync;
    chg_set     = (sw_sync != sw_stable_q);
  end
`endif

  // --------------------------------------------------------------------------
  // Sticky change flag: cleared by a status read, set has priority
  // --------------------------------------------------------------------------
  logic chg_flag_q, chg_flag_d;
  logic sw_rd;

  assign sw_rd = ioRead && SwitchCtrl;

  always_comb begin
    chg_flag_d = chg_flag_q;
    if (sw_rd && (addr_low == OFS_STAT)) begin
      chg_flag_d = 1'b0;
    end
    if (chg_set) begin
      chg_flag_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Combinational read mux
  // --------------------------------------------------------------------------
  always_comb begin
    io_rdata = 16'h0000;
    if (sw_rd) begin
      case (addr_low)
        OFS_LO:   io_rdata = sw_stable_q[15:0];
        OFS_HI:   io_rdata = {8'h00, sw_stable_q[23:16]};
        OFS_STAT: io_rdata = {15'h0000, chg_flag_q};
        default:  io_rdata = 16'h0000;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_q       <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sw_stable_q <= '0;
      chg_flag_q  <= 1'b0;
    end else begin
      led_q       <= led_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sw_stable_q <= sw_stable_d;
      chg_flag_q  <= chg_flag_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_led_switch_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_led_switch_port
// Purpose  : Self-checking bench for io_led_switch_port (DEBOUNCE_CYCLES=4).
//            Table of bus vectors for LED writes and register reads, plus
//            hand-written sequences for reset, switch latency, glitch
//            handling and the status set/clear collision.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_led_switch_port;

  localparam int unsigned DBC = 4;
`ifdef IO_DEBOUNCE_EN
  localparam int LAT = 2 + DBC;
`else
  localparam int LAT = 3;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        ioRead, ioWrite, LEDCtrl, SwitchCtrl;
  logic [2:0]  addr_low;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic [23:0] switch_in;
  logic [23:0] led_out;

  int n_cmp = 0;
  int n_bad = 0;

  io_led_switch_port #(
    .DEBOUNCE_CYCLES (DBC),
    .CNT_W           (20)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ioRead     (ioRead),
    .ioWrite    (ioWrite),
    .LEDCtrl    (LEDCtrl),
    .SwitchCtrl (SwitchCtrl),
    .addr_low   (addr_low),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .switch_in  (switch_in),
    .led_out    (led_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        led;
    logic        sw;
    logic [2:0]  a;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    logic [23:0] exp_led;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    ioRead     = 1'b0;
    ioWrite    = 1'b0;
    LEDCtrl    = 1'b0;
    SwitchCtrl = 1'b0;
    addr_low   = 3'd0;
    io_wdata   = 16'h0000;
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Non-destructive look at a switch register within the current cycle.
  task automatic peek(input logic [2:0] a, output logic [15:0] d);
    ioRead     = 1'b1;
    SwitchCtrl = 1'b1;
    addr_low   = a;
    #1;
    d          = io_rdata;
    ioRead     = 1'b0;
    SwitchCtrl = 1'b0;
    addr_low   = 3'd0;
  endtask

  task automatic clear_flag();
    ioRead     = 1'b1;
    SwitchCtrl = 1'b1;
    addr_low   = 3'd4;
    tick();
    idle_bus();
  endtask

  // Edges until offset 0 reads exp; -1 when the bound expires.
  task automatic measure(input logic [15:0] exp, output int n);
    logic [15:0] d;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      peek(3'd0, d);
      if (d == exp) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    int          n;

    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h1234, 16'h0000, 24'h001234};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 16'hFF56, 16'h0000, 24'h561234};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 16'hBEEF, 16'h0000, 24'h561234};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'hAAAA, 16'h0000, 24'h561234};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 16'hCDEF, 24'h561234};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0000, 16'h00AB, 24'h561234};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0000, 16'h0001, 24'h561234};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0000, 16'h0000, 24'h561234};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 16'h0000, 16'h0000, 24'h561234};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000, 24'h561234};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'hFFFF, 16'h0000, 24'h561234};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 24'h561234};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 16'h0000, 24'h561234};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0BAD, 16'hCDEF, 24'h560BAD};

    // ---------------- power-on reset ----------------
    reset     = 1'b1;
    switch_in = 24'h000000;
    idle_bus();
    tick();
    tick();
    check("por_led", led_out, 24'h0);
    peek(3'd0, d);
    check("por_rd0", {8'h0, d}, 24'h0);

    // ---------------- mid-run reset ----------------
    reset    = 1'b0;
    ioWrite  = 1'b1;
    LEDCtrl  = 1'b1;
    io_wdata = 16'h0777;
    tick();
    idle_bus();
    check("led_pre_reset", led_out, 24'h000777);
    switch_in = 24'hABCDEF;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rst_led", led_out, 24'h0);
    peek(3'd0, d);
    check("rst_rd0", {8'h0, d}, 24'h0);
    peek(3'd4, d);
    check("rst_flag", {8'h0, d}, 24'h0);
    tick();
    tick();
    reset = 1'b0;
    measure(16'hCDEF, n);
    check("rst_release_latency", n, LAT);

    // ---------------- bus vector table ----------------
    for (int i = 0; i < NV; i++) begin
      ioRead     = vecs[i].rd;
      ioWrite    = vecs[i].wr;
      LEDCtrl    = vecs[i].led;
      SwitchCtrl = vecs[i].sw;
      addr_low   = vecs[i].a;
      io_wdata   = vecs[i].wd;
      #1;
      check($sformatf("vec%0d_rdata", i), {8'h0, io_rdata}, {8'h0, vecs[i].exp_rd});
      tick();
      check($sformatf("vec%0d_led", i), led_out, vecs[i].exp_led);
      idle_bus();
    end

    // ---------------- clean step acceptance ----------------
    switch_in = 24'h000000;
    repeat (10) tick();
    clear_flag();
    switch_in = 24'h00F00F;
    measure(16'hF00F, n);
    check("step_latency", n, LAT);
    peek(3'd2, d);
    check("step_rd2", {8'h0, d}, 24'h0);
    ioRead     = 1'b1;
    SwitchCtrl = 1'b1;
    addr_low   = 3'd4;
    #1;
    check("step_flag_set", {8'h0, io_rdata}, 24'h1);
    tick();
    check("step_flag_cleared", {8'h0, io_rdata}, 24'h0);
    idle_bus();

    // ---------------- set/clear collision ----------------
    switch_in = 24'h000F00;
    repeat (LAT - 1) tick();
    ioRead     = 1'b1;
    SwitchCtrl = 1'b1;
    addr_low   = 3'd4;
    #1;
    check("coll_pre", {8'h0, io_rdata}, 24'h0);
    tick();
    check("coll_post", {8'h0, io_rdata}, 24'h1);
    idle_bus();
    peek(3'd0, d);
    check("coll_rd0", {8'h0, d}, 24'h000F00);

    // ---------------- reset aborts a pending update ----------------
    switch_in = 24'h000000;
    repeat (10) tick();
    clear_flag();
    switch_in = 24'h00F00F;
    repeat (LAT - 1) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    peek(3'd0, d);
    check("abort_rd0", {8'h0, d}, 24'h0);
    repeat (LAT - 1) tick();
    peek(3'd0, d);
    check("abort_restart_early", {8'h0, d}, 24'h0);
    tick();
    peek(3'd0, d);
    check("abort_restart_done", {8'h0, d}, 24'h00F00F);

`ifdef IO_DEBOUNCE_EN
    // ---------------- glitch rejected (3 clocks) ----------------
    switch_in = 24'h000000;
    repeat (10) tick();
    clear_flag();
    switch_in = 24'h000001;
    repeat (3) tick();
    switch_in = 24'h000000;
    repeat (10) tick();
    peek(3'd0, d);
    check("glitch3_rd0", {8'h0, d}, 24'h0);
    peek(3'd4, d);
    check("glitch3_flag", {8'h0, d}, 24'h0);

    // ---------------- pulse of exactly DEBOUNCE_CYCLES accepted ----------
    switch_in = 24'h000001;
    repeat (DBC) tick();
    switch_in = 24'h000000;
    repeat (2) tick();
    peek(3'd0, d);
    check("pulse4_accept", {8'h0, d}, 24'h1);
    repeat (10) tick();
    peek(3'd4, d);
    check("pulse4_flag", {8'h0, d}, 24'h1);
`else
    // ---------------- single-clock change passes after 3 clocks ----------
    switch_in = 24'h000000;
    repeat (10) tick();
    clear_flag();
    switch_in = 24'h000001;
    tick();
    switch_in = 24'h000000;
    tick();
    peek(3'd0, d);
    check("pulse_early", {8'h0, d}, 24'h0);
    tick();
    peek(3'd0, d);
    check("pulse_seen", {8'h0, d}, 24'h1);
    tick();
    peek(3'd0, d);
    check("pulse_gone", {8'h0, d}, 24'h0);
    peek(3'd4, d);
    check("pulse_flag", {8'h0, d}, 24'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
